bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Parametrised N-leader to 1-follower arbiter for the core's simple request bus: addr, write_data, byte_enable, read_req, write_req, read_data, read_data_valid.
- Lets the fetch unit, the load/store unit and debug/DMA share one memory follower. It adds a per-leader accept handshake, round-robin fairness and in-order routing of multiple outstanding read responses.
- Sits between the leaders and the memory/peripheral decoder.

Parameters:
- N_LEADERS, 2, number of leader ports (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8; byte_enable width is DATA_W/8.
- MAX_OUTSTANDING, 4, maximum reads issued to the follower but not yet returned (power of two, >= 1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- l_addr  in  N_LEADERS*ADDR_W  per-leader address
- l_write_data  in  N_LEADERS*DATA_W  per-leader write data
- l_byte_enable  in  N_LEADERS*(DATA_W/8)  per-leader byte enables
- l_read_req  in  N_LEADERS  per-leader read request, held until accepted
- l_write_req  in  N_LEADERS  per-leader write request, held until accepted
- l_accept  out  N_LEADERS  one-hot pulse: request consumed this cycle
- l_read_data  out  DATA_W  follower read data, broadcast to all leaders
- l_read_data_valid  out  N_LEADERS  one-hot: response belongs to this leader
- f_addr  out  ADDR_W  follower address (registered)
- f_write_data  out  DATA_W  follower write data (registered)
- f_byte_enable  out  DATA_W/8  follower byte enables (registered)
- f_read_req  out  1  follower read strobe, single cycle
- f_write_req  out  1  follower write strobe, single cycle
- f_read_data  in  DATA_W  follower read data
- f_read_data_valid  in  1  follower response strobe; responses return in issue order
- err_unexpected  out  1  sticky: response arrived with no read outstanding

Behaviour:
- Reset (rst_n low, asynchronous): all f_* outputs and err_unexpected go to 0. Round-robin pointer goes to leader 0. Outstanding FIFO is emptied.
- Leader request: valid when l_read_req[i] or l_write_req[i] is set.
  - Leader holds addr, data and byte_enable stable until l_accept[i].
  - If both strobes are set, the request is treated as a write (simulation assertion fires).
- Arbitration (combinational, every cycle):
  - Eligible leaders: requesting leaders, excluding reads when the FIFO count equals MAX_OUTSTANDING.
  - Winner: the first eligible leader at or after the pointer, searching in ascending index order with wrap-around.
  - l_accept[winner] = 1. At most one accept per cycle.
- Issue: on the accept edge, the winner's request is registered onto f_*.
  - f_read_req or f_write_req is high for exactly the next cycle (1-cycle latency), then returns to 0.
  - f_addr, f_write_data and f_byte_enable hold their last values while idle.
- Pointer: after an accept, the pointer moves to winner+1 modulo N_LEADERS. With no accept it is unchanged.
- Read tracking: each accepted read pushes the winner index into sub-module bus_id_fifo. Writes push nothing and get no response.
- Response routing:
  - l_read_data = f_read_data (combinational).
  - When f_read_data_valid is high, l_read_data_valid[head id] = 1 in the same cycle and the FIFO pops.
  - A response in the same cycle as f_read_req is legal if the FIFO is non-empty.
- Simultaneous push and pop: count is unchanged. A full-FIFO read is not granted even when a pop occurs that cycle (conservative stall).
- Unexpected response: f_read_data_valid with an empty FIFO is dropped; no l_read_data_valid; err_unexpected is set and cleared only by reset.
- Reset mid-transaction: outstanding ids are discarded. The follower must be reset by the same rst_n.
- No combinational path from f_read_data_valid to l_accept.

Decomposition:
- Package bus_pkg:
  - leader_id_t (logic [$clog2(N_LEADERS)-1:0], minimum 1 bit).
  - Request-type enum {REQ_NONE, REQ_READ, REQ_WRITE}.
  - Function byte_en_width(DATA_W).
- Sub-module bus_id_fifo (DEPTH = MAX_OUTSTANDING, WIDTH = leader id width):
  - Circular buffer with read/write pointers one bit wider than the index for full/empty detection.
  - Outputs: count, full, empty, head.
- Top level contains the arbiter, pointer and output registers.

Test Plan:
- Single leader 0 writes addr 0x100, data 0xDEADBEEF, be 0xF -> l_accept[0] in cycle 0; f_write_req=1 with matching fields in cycle 1 only; no l_read_data_valid.
- Leaders 0 and 1 request continuously with pointer at 0 -> accepts alternate 0,1,0,1; each leader gets exactly 4 of 8 cycles.
- Leader 1 issues 4 reads (0x10, 0x14, 0x18, 0x1C); follower stalls its responses -> 5th read not accepted while a leader-0 write is accepted; after the first response, the 5th read is accepted the next cycle.
- Interleaved reads L0@0x0, L1@0x4, L0@0x8; follower returns 0xA, 0xB, 0xC in order -> l_read_data_valid sequence 01, 10, 01 with matching l_read_data.
- f_read_data_valid pulse with no outstanding reads -> err_unexpected=1 and stays 1; no leader valid; a following normal read still completes.
- rst_n low mid-burst with 2 reads outstanding -> all f_* = 0 and err_unexpected = 0 immediately (asynchronous); after release, the FIFO is empty and the pointer is at leader 0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and helpers for the leader/follower request-bus arbiter.
//   req_type_e     : kind of request a leader is presenting
//   byte_en_width  : byte-enable width for a given data width
//   id_width       : width of a leader index (at least one bit)
// leader_id_t itself depends on the instance's leader count, so each user
// declares it locally as logic [id_width(N_LEADERS)-1:0].
package bus_pkg;

   typedef enum logic [1:0] {
      REQ_NONE  = 2'd0,
      REQ_READ  = 2'd1,
      REQ_WRITE = 2'd2
   } req_type_e;

   function automatic int unsigned byte_en_width(input int unsigned data_w);
      return data_w / 8;
   endfunction

   function automatic int unsigned id_width(input int unsigned n_leaders);
      return (n_leaders > 1) ? $clog2(n_leaders) : 1;
   endfunction

endpackage

// File: rtl/bus_id_fifo.sv
// In-order FIFO of leader ids for reads that have been issued to the
// follower but whose response has not come back yet.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push       : store push_id at the tail (ignored when full)
//   push_id    : leader index of the read just accepted
//   pop        : drop the head entry (ignored when empty)
//   head       : leader index the next response belongs to
//   count      : number of entries held (0..DEPTH)
//   full/empty : count == DEPTH / count == 0
module bus_id_fifo
   import bus_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_id,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   // Pointers carry one extra wrap bit, so the pointer difference is the
   // fill level and full/empty need no separate flag.
   localparam int unsigned PW = $clog2(DEPTH) + 1;
   localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Modulo rather than a plain slice keeps DEPTH == 1 (zero index bits) legal.
   function automatic logic [IW-1:0] slot(input logic [PW-1:0] p);
      return IW'(32'(p) % DEPTH);
   endfunction

   assign count   = wr_ptr - rd_ptr;
   assign full    = (count == PW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[slot(rd_ptr)];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[slot(wr_ptr)] <= push_id;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// N-leader to 1-follower arbiter for the simple request bus. Round-robin
// grant with a one-hot accept pulse, registered single-cycle follower
// strobes, and in-order routing of up to MAX_OUTSTANDING read responses
// back to the leader that issued each read.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   l_addr / l_write_data / l_byte_enable : per-leader request fields (packed, leader 0 in LSBs)
//   l_read_req / l_write_req : per-leader request strobes, held until accepted
//   l_accept           : one-hot, request consumed this cycle
//   l_read_data        : follower read data broadcast to all leaders
//   l_read_data_valid  : one-hot, the response on l_read_data belongs to this leader
//   f_addr / f_write_data / f_byte_enable : registered follower request fields
//   f_read_req / f_write_req : single-cycle follower strobes
//   f_read_data / f_read_data_valid : follower response, in issue order
//   err_unexpected     : sticky, a response arrived with nothing outstanding
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int unsigned N_LEADERS       = 2,
   parameter int unsigned ADDR_W          = 32,
   parameter int unsigned DATA_W          = 32,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic [N_LEADERS*ADDR_W-1:0]               l_addr,
   input  logic [N_LEADERS*DATA_W-1:0]               l_write_data,
   input  logic [N_LEADERS*byte_en_width(DATA_W)-1:0] l_byte_enable,
   input  logic [N_LEADERS-1:0]                      l_read_req,
   input  logic [N_LEADERS-1:0]                      l_write_req,
   output logic [N_LEADERS-1:0]                      l_accept,
   output logic [DATA_W-1:0]                         l_read_data,
   output logic [N_LEADERS-1:0]                      l_read_data_valid,
   output logic [ADDR_W-1:0]                         f_addr,
   output logic [DATA_W-1:0]                         f_write_data,
   output logic [byte_en_width(DATA_W)-1:0]          f_byte_enable,
   output logic                                      f_read_req,
   output logic                                      f_write_req,
   input  logic [DATA_W-1:0]                         f_read_data,
   input  logic                                      f_read_data_valid,
   output logic                                      err_unexpected
);

   localparam int unsigned BE_W  = byte_en_width(DATA_W);
   localparam int unsigned ID_W  = id_width(N_LEADERS);
   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

   typedef logic [ID_W-1:0] leader_id_t;

   leader_id_t           rr_ptr;
   leader_id_t           win_id;
   leader_id_t           head_id;
   logic                 win_found;
   logic                 win_rd;
   req_type_e            win_type;
   logic [N_LEADERS-1:0] req_any;
   logic [N_LEADERS-1:0] req_rd;
   logic [N_LEADERS-1:0] eligible;
   logic [ADDR_W-1:0]    sel_addr;
   logic [DATA_W-1:0]    sel_data;
   logic [BE_W-1:0]      sel_be;
   logic                 fifo_push;
   logic                 fifo_pop;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [CNT_W-1:0]     fifo_count;

   // A request with both strobes set counts as a write.
   assign req_any = l_read_req | l_write_req;
   assign req_rd  = l_read_req & ~l_write_req;

   // Reads stall on the registered fill level only; a pop in the same cycle
   // does not free a slot until the next cycle, which keeps
   // f_read_data_valid out of the accept path.
   assign eligible = req_any & ~(req_rd & {N_LEADERS{fifo_full}});

   // Winner = lowest eligible index at or above rr_ptr, otherwise the lowest
   // eligible index overall (wrap-around). Loops run high-to-low so the last
   // match is the lowest index.
   always_comb begin
      win_found = |eligible;
      win_id    = '0;
      for (int i = N_LEADERS - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            win_id = leader_id_t'(i);
         end
      end
      for (int i = N_LEADERS - 1; i >= 0; i--) begin
         if (eligible[i] && (i >= int'(rr_ptr))) begin
            win_id = leader_id_t'(i);
         end
      end
   end

   always_comb begin
      l_accept = '0;
      if (win_found) begin
         l_accept[win_id] = 1'b1;
      end
   end

   // l_accept is one-hot, so it doubles as the field mux select.
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      sel_be   = '0;
      win_rd   = 1'b0;
      for (int i = 0; i < N_LEADERS; i++) begin
         if (l_accept[i]) begin
            sel_addr = l_addr[i*ADDR_W +: ADDR_W];
            sel_data = l_write_data[i*DATA_W +: DATA_W];
            sel_be   = l_byte_enable[i*BE_W +: BE_W];
            win_rd   = req_rd[i];
         end
      end
   end

   always_comb begin
      win_type = REQ_NONE;
      if (win_found) begin
         win_type = win_rd ? REQ_READ : REQ_WRITE;
      end
   end

   assign fifo_push = (win_type == REQ_READ);
   assign fifo_pop  = f_read_data_valid && !fifo_empty;

   bus_id_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH (ID_W)
   ) u_id_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (fifo_push),
      .push_id (win_id),
      .pop     (fifo_pop),
      .head    (head_id),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_addr         <= '0;
         f_write_data   <= '0;
         f_byte_enable  <= '0;
         f_read_req     <= 1'b0;
         f_write_req    <= 1'b0;
         rr_ptr         <= '0;
         err_unexpected <= 1'b0;
      end else begin
         f_read_req  <= (win_type == REQ_READ);
         f_write_req <= (win_type == REQ_WRITE);
         if (win_found) begin
            f_addr        <= sel_addr;
            f_write_data  <= sel_data;
            f_byte_enable <= sel_be;
            rr_ptr        <= (32'(win_id) == N_LEADERS - 1) ? '0 : win_id + leader_id_t'(1);
         end
         if (f_read_data_valid && fifo_empty) begin
            err_unexpected <= 1'b1;
         end
      end
   end

   assign l_read_data = f_read_data;

   always_comb begin
      l_read_data_valid = '0;
      if (fifo_pop) begin
         l_read_data_valid[head_id] = 1'b1;
      end
   end

   a_single_strobe : assert property (@(posedge clk) disable iff (!rst_n)
      (l_read_req & l_write_req) == '0);
   a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
      fifo_count <= CNT_W'(MAX_OUTSTANDING));
   a_no_push_full : assert property (@(posedge clk) disable iff (!rst_n)
      !(fifo_push && fifo_full));

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

   localparam int N    = 3;
   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int BW   = DW / 8;
   localparam int MAXO = 4;

   logic              clk;
   logic              rst_n;
   logic [N*AW-1:0]   l_addr;
   logic [N*DW-1:0]   l_write_data;
   logic [N*BW-1:0]   l_byte_enable;
   logic [N-1:0]      l_read_req;
   logic [N-1:0]      l_write_req;
   logic [N-1:0]      l_accept;
   logic [DW-1:0]     l_read_data;
   logic [N-1:0]      l_read_data_valid;
   logic [AW-1:0]     f_addr;
   logic [DW-1:0]     f_write_data;
   logic [BW-1:0]     f_byte_enable;
   logic              f_read_req;
   logic              f_write_req;
   logic [DW-1:0]     f_read_data;
   logic              f_read_data_valid;
   logic              err_unexpected;

   bus_arbiter #(
      .N_LEADERS       (N),
      .ADDR_W          (AW),
      .DATA_W          (DW),
      .MAX_OUTSTANDING (MAXO)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .l_addr            (l_addr),
      .l_write_data      (l_write_data),
      .l_byte_enable     (l_byte_enable),
      .l_read_req        (l_read_req),
      .l_write_req       (l_write_req),
      .l_accept          (l_accept),
      .l_read_data       (l_read_data),
      .l_read_data_valid (l_read_data_valid),
      .f_addr            (f_addr),
      .f_write_data      (f_write_data),
      .f_byte_enable     (f_byte_enable),
      .f_read_req        (f_read_req),
      .f_write_req       (f_write_req),
      .f_read_data       (f_read_data),
      .f_read_data_valid (f_read_data_valid),
      .err_unexpected    (err_unexpected)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      int          due;
      bit          rd;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } f_exp_t;

   typedef struct {
      int          leader;
      logic [31:0] data;
   } resp_exp_t;

   int total = 0;
   int bad   = 0;

   // leader request state: 0 idle, 1 read, 2 write
   int          req_kind [N];
   logic [31:0] r_addr   [N];
   logic [31:0] r_data   [N];
   logic [3:0]  r_be     [N];

   // reference model
   int          m_ptr;
   int          m_out_q[$];
   bit          m_err;
   int          cyc;
   int          fol_cnt;
   bit          mon_en;
   f_exp_t      exp_f_q[$];
   resp_exp_t   exp_resp_q[$];
   logic [31:0] last_addr;
   logic [31:0] last_data;
   logic [3:0]  last_be;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive_leaders();
      for (int i = 0; i < N; i++) begin
         l_read_req[i]               = (req_kind[i] == 1);
         l_write_req[i]              = (req_kind[i] == 2);
         l_addr[i*AW +: AW]          = r_addr[i];
         l_write_data[i*DW +: DW]    = r_data[i];
         l_byte_enable[i*BW +: BW]   = r_be[i];
      end
   endtask

   task automatic set_req(input int id, input int kind, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b);
      req_kind[id] = kind;
      r_addr[id]   = a;
      r_data[id]   = d;
      r_be[id]     = b;
   endtask

   task automatic model_reset();
      m_ptr   = 0;
      m_out_q.delete();
      m_err   = 1'b0;
      fol_cnt = 0;
      exp_f_q.delete();
      exp_resp_q.delete();
      last_addr = '0;
      last_data = '0;
      last_be   = '0;
      for (int i = 0; i < N; i++) set_req(i, 0, '0, '0, '0);
   endtask

   // One bus cycle: drive inputs just after the edge, predict from the model,
   // check accept/err on the falling edge. Returns the DUT's accept vector.
   task automatic cycle(input bit want_resp, input logic [31:0] rdata, input bit stray,
                        output logic [N-1:0] acc);
      int cnt;
      int win;
      int c;
      bit resp_now;
      bit stray_now;
      f_exp_t fe;
      logic [N-1:0] exp_acc;
      @(posedge clk);
      #1;
      cyc++;
      resp_now  = 1'b0;
      stray_now = 1'b0;
      cnt = m_out_q.size();
      f_read_data_valid = 1'b0;
      f_read_data = $urandom;
      if (want_resp && fol_cnt > 0) begin
         f_read_data_valid = 1'b1;
         f_read_data = rdata;
         fol_cnt--;
         resp_now = 1'b1;
         exp_resp_q.push_back('{leader: m_out_q[0], data: rdata});
      end else if (stray && cnt == 0) begin
         f_read_data_valid = 1'b1;
         stray_now = 1'b1;
      end
      drive_leaders();
      win = -1;
      for (int k = 0; k < N; k++) begin
         c = (m_ptr + k) % N;
         if (win < 0 && req_kind[c] != 0 && !(req_kind[c] == 1 && cnt == MAXO)) win = c;
      end
      if (resp_now) void'(m_out_q.pop_front());
      exp_acc = '0;
      if (win >= 0) begin
         exp_acc[win] = 1'b1;
         fe.due  = cyc + 1;
         fe.rd   = (req_kind[win] == 1);
         fe.addr = r_addr[win];
         fe.data = r_data[win];
         fe.be   = r_be[win];
         exp_f_q.push_back(fe);
         if (fe.rd) m_out_q.push_back(win);
         m_ptr = (win + 1) % N;
         req_kind[win] = 0;
      end
      @(negedge clk);
      acc = l_accept;
      check("accept", l_accept, exp_acc);
      check("err_unexpected", err_unexpected, m_err);
      if (stray_now) m_err = 1'b1;
   endtask

   task automatic drain();
      logic [N-1:0] acc;
      int guard;
      guard = 0;
      while ((m_out_q.size() > 0 || fol_cnt > 0 || exp_f_q.size() > 0 ||
              req_kind[0] != 0 || req_kind[1] != 0 || req_kind[2] != 0) && guard < 200) begin
         cycle(1'b1, $urandom, 1'b0, acc);
         guard++;
      end
      check("drain_bound", guard < 200, 1'b1);
   endtask

   // Monitor: follower strobes/fields and leader-side responses.
   initial begin
      resp_exp_t r;
      f_exp_t    e;
      bit        due;
      logic [N-1:0] v;
      forever begin
         @(negedge clk);
         #1;
         if (mon_en) begin
            due = (exp_f_q.size() > 0) && (exp_f_q[0].due == cyc);
            e = '{due: 0, rd: 0, addr: '0, data: '0, be: '0};
            if (due) e = exp_f_q.pop_front();
            check("f_read_req", f_read_req, due && e.rd);
            check("f_write_req", f_write_req, due && !e.rd);
            if (due) begin
               last_addr = e.addr;
               last_data = e.data;
               last_be   = e.be;
               if (e.rd) fol_cnt++;
            end
            check("f_addr", f_addr, last_addr);
            check("f_write_data", f_write_data, last_data);
            check("f_byte_enable", f_byte_enable, last_be);
            v = '0;
            if (exp_resp_q.size() > 0) begin
               r = exp_resp_q.pop_front();
               v[r.leader] = 1'b1;
               check("rd_valid", l_read_data_valid, v);
               check("rd_data", l_read_data, r.data);
            end else begin
               check("rd_valid_idle", l_read_data_valid, v);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] acc;
      int cnt0;
      int cnt1;
      mon_en = 1'b0;
      cyc = 0;
      rst_n = 1'b0;
      f_read_data = '0;
      f_read_data_valid = 1'b0;
      model_reset();
      drive_leaders();

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_f_read_req", f_read_req, 1'b0);
      check("rst_f_write_req", f_write_req, 1'b0);
      check("rst_f_addr", f_addr, '0);
      check("rst_f_write_data", f_write_data, '0);
      check("rst_f_byte_enable", f_byte_enable, '0);
      check("rst_err", err_unexpected, 1'b0);
      check("rst_accept", l_accept, '0);
      #2;
      rst_n = 1'b1;
      mon_en = 1'b1;

      // single write from leader 0
      set_req(0, 2, 32'h100, 32'hDEADBEEF, 4'hF);
      cycle(1'b0, '0, 1'b0, acc);
      check("t1_accept0", acc, 3'b001);
      cycle(1'b0, '0, 1'b0, acc);
      cycle(1'b0, '0, 1'b0, acc);

      // two leaders requesting continuously share 8 cycles evenly
      cnt0 = 0;
      cnt1 = 0;
      for (int k = 0; k < 8; k++) begin
         if (req_kind[0] == 0) set_req(0, 2, 32'h200 + k, $urandom, 4'h3);
         if (req_kind[1] == 0) set_req(1, 2, 32'h300 + k, $urandom, 4'hC);
         cycle(1'b0, '0, 1'b0, acc);
         cnt0 += int'(acc[0]);
         cnt1 += int'(acc[1]);
      end
      check("t2_share0", cnt0, 4);
      check("t2_share1", cnt1, 4);
      drain();

      // outstanding limit: four reads fill the id FIFO
      for (int k = 0; k < 4; k++) begin
         set_req(1, 1, 32'h10 + 4*k, '0, 4'hF);
         cycle(1'b0, '0, 1'b0, acc);
      end
      set_req(1, 1, 32'h20, '0, 4'hF);
      set_req(0, 2, 32'h400, 32'h1234_5678, 4'h1);
      cycle(1'b0, '0, 1'b0, acc);
      check("t3_fifth_read_blocked", acc[1], 1'b0);
      check("t3_write_passes", acc[0], 1'b1);
      cycle(1'b0, '0, 1'b0, acc);
      check("t3_still_blocked", acc[1], 1'b0);
      cycle(1'b1, 32'h5555_0001, 1'b0, acc);
      check("t3_blocked_on_pop_cycle", acc[1], 1'b0);
      cycle(1'b0, '0, 1'b0, acc);
      check("t3_fifth_read_after_pop", acc[1], 1'b1);
      drain();

      // interleaved reads routed back in order
      set_req(0, 1, 32'h0, '0, 4'hF);
      cycle(1'b0, '0, 1'b0, acc);
      set_req(1, 1, 32'h4, '0, 4'hF);
      cycle(1'b0, '0, 1'b0, acc);
      set_req(0, 1, 32'h8, '0, 4'hF);
      cycle(1'b0, '0, 1'b0, acc);
      cycle(1'b1, 32'hA, 1'b0, acc);
      cycle(1'b1, 32'hB, 1'b0, acc);
      cycle(1'b1, 32'hC, 1'b0, acc);
      drain();

      // stray response with nothing outstanding
      cycle(1'b0, '0, 1'b1, acc);
      cycle(1'b0, '0, 1'b0, acc);
      check("t5_err_set", err_unexpected, 1'b1);
      set_req(2, 1, 32'h40, '0, 4'hF);
      drain();

      // asynchronous reset with two reads outstanding
      set_req(0, 1, 32'h80, '0, 4'hF);
      cycle(1'b0, '0, 1'b0, acc);
      set_req(1, 1, 32'h84, '0, 4'hF);
      cycle(1'b0, '0, 1'b0, acc);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      mon_en = 1'b0;
      #1;
      check("t6_f_read_req", f_read_req, 1'b0);
      check("t6_f_write_req", f_write_req, 1'b0);
      check("t6_f_addr", f_addr, '0);
      check("t6_f_write_data", f_write_data, '0);
      check("t6_f_byte_enable", f_byte_enable, '0);
      check("t6_err", err_unexpected, 1'b0);
      model_reset();
      f_read_data_valid = 1'b0;
      drive_leaders();
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      mon_en = 1'b1;
      // pointer back at 0: leader 1 must beat leader 2
      set_req(1, 2, 32'h500, 32'h1111_2222, 4'h6);
      set_req(2, 2, 32'h600, 32'h3333_4444, 4'h9);
      cycle(1'b0, '0, 1'b0, acc);
      check("t6_ptr_reset", acc, 3'b010);
      drain();
      // FIFO was emptied: any response now is unexpected
      cycle(1'b0, '0, 1'b1, acc);
      cycle(1'b0, '0, 1'b0, acc);
      check("t6_fifo_empty_after_reset", err_unexpected, 1'b1);

      // randomized traffic
      for (int k = 0; k < 1500; k++) begin
         for (int i = 0; i < N; i++) begin
            if (req_kind[i] == 0 && $urandom_range(0, 2) == 0) begin
               set_req(i, int'($urandom_range(1, 2)), $urandom & 32'hFFFF_FFFC,
                       $urandom, 4'($urandom_range(0, 15)));
            end
         end
         cycle($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 49) == 0, acc);
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
